ddr3_app_arbiter: RTL



---
 rtl/ddr3_arb_pkg.sv | 16 +
 rtl/ddr3_app_arbiter_if.sv | 52 +++++
 rtl/ddr3_arb_tag_fifo.sv | 48 ++++
 rtl/ddr3_app_arbiter.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/ddr3_arb_pkg.sv
// Shared constants and types for the two-port DDR3 app-interface arbiter.
package ddr3_arb_pkg;

    localparam int DEF_ADDR_W = 29;
    localparam int DEF_DATA_W = 256;
    localparam int DEF_MASK_W = DEF_DATA_W / 8;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } arb_state_t;

endpackage

// File: rtl/ddr3_app_arbiter_if.sv
// Requester and controller-facing signals of the arbiter; master = arbiter side.
interface ddr3_app_arbiter_if #(
    parameter int ADDR_W = ddr3_arb_pkg::DEF_ADDR_W,
    parameter int DATA_W = ddr3_arb_pkg::DEF_DATA_W
);
    localparam int MASK_W = DATA_W / 8;

    logic              p0_req_valid, p1_req_valid;
    logic              p0_req_ready, p1_req_ready;
    logic              p0_req_write, p1_req_write;
    logic [ADDR_W-1:0] p0_req_addr,  p1_req_addr;
    logic [DATA_W-1:0] p0_req_wdata, p1_req_wdata;
    logic [MASK_W-1:0] p0_req_wmask, p1_req_wmask;
    logic              p0_rd_valid,  p1_rd_valid;
    logic [DATA_W-1:0] p0_rd_data,   p1_rd_data;

    logic              app_en;
    logic [2:0]        app_cmd;
    logic [ADDR_W-1:0] app_addr;
    logic              app_wdf_wren;
    logic              app_wdf_end;
    logic [DATA_W-1:0] app_wdf_data;
    logic [MASK_W-1:0] app_wdf_mask;
    logic              app_rdy;
    logic              app_wdf_rdy;
    logic              app_rd_data_valid;
    logic [DATA_W-1:0] app_rd_data;
    logic              app_rd_data_end;

    modport master (
        input  p0_req_valid, p1_req_valid, p0_req_write, p1_req_write,
        input  p0_req_addr, p1_req_addr, p0_req_wdata, p1_req_wdata,
        input  p0_req_wmask, p1_req_wmask,
        output p0_req_ready, p1_req_ready,
        output p0_rd_valid, p1_rd_valid, p0_rd_data, p1_rd_data,
        output app_en, app_cmd, app_addr,
        output app_wdf_wren, app_wdf_end, app_wdf_data, app_wdf_mask,
        input  app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data, app_rd_data_end
    );

    modport slave (
        output p0_req_valid, p1_req_valid, p0_req_write, p1_req_write,
        output p0_req_addr, p1_req_addr, p0_req_wdata, p1_req_wdata,
        output p0_req_wmask, p1_req_wmask,
        input  p0_req_ready, p1_req_ready,
        input  p0_rd_valid, p1_rd_valid, p0_rd_data, p1_rd_data,
        input  app_en, app_cmd, app_addr,
        input  app_wdf_wren, app_wdf_end, app_wdf_data, app_wdf_mask,
        output app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data, app_rd_data_end
    );

endinterface

// File: rtl/ddr3_arb_tag_fifo.sv
// 1-bit tag FIFO holding the issuing port id of each outstanding read.
module ddr3_arb_tag_fifo #(
    parameter int DEPTH = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic push_data,
    input  logic pop,
    output logic pop_data,
    output logic full,
    output logic empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push, do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (PTR_W + 1)'(DEPTH));
    assign do_pop   = pop & ~empty;
    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ddr3_app_arbiter.sv
// Two-port round-robin arbiter in front of the DDR3 controller app interface,
// with in-order read data routing through a tag FIFO.
module ddr3_app_arbiter
    import ddr3_arb_pkg::*;
#(
    parameter int RD_DEPTH = 16,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W
) (
    input  logic               ui_clk,
    input  logic               ui_rst_n,
    input  logic               init_calib_complete,
    ddr3_app_arbiter_if.master bus,
    output logic               rd_orphan_err
);
    localparam int MASK_W = DATA_W / 8;

    arb_state_t        state;
    logic              last_grant, cur_port;
    logic              cmd_done, data_done;
    logic              app_en_q, wren_q, wend_q;
    logic [2:0]        cmd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [MASK_W-1:0] wmask_q;

    logic              tag_full, tag_empty, tag_pop_data, tag_push, tag_pop;
    logic              elig0, elig1, can_grant, grant0, grant1, grant_any;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [MASK_W-1:0] sel_wmask;
    logic              cmd_fire, data_fire, cmd_ok, data_ok;

    logic [1:0]        rd_vld_p1;
    logic [DATA_W-1:0] rd_data_p1;
    logic              unused_rd_end;

    assign unused_rd_end = bus.app_rd_data_end;

    assign tag_pop  = bus.app_rd_data_valid & ~tag_empty;
    assign tag_push = app_en_q & bus.app_rdy & (cmd_q == CMD_READ);

    // A pop in the grant cycle frees a slot, so a read may go even when full.
    assign elig0 = bus.p0_req_valid & (bus.p0_req_write | ~tag_full | tag_pop);
    assign elig1 = bus.p1_req_valid & (bus.p1_req_write | ~tag_full | tag_pop);

    assign can_grant = (state == IDLE) & init_calib_complete;
    assign grant0    = can_grant & elig0 & (~elig1 | last_grant);
    assign grant1    = can_grant & elig1 & (~elig0 | ~last_grant);
    assign grant_any = grant0 | grant1;

    assign sel_write = grant1 ? bus.p1_req_write : bus.p0_req_write;
    assign sel_addr  = grant1 ? bus.p1_req_addr  : bus.p0_req_addr;
    assign sel_wdata = grant1 ? bus.p1_req_wdata : bus.p0_req_wdata;
    assign sel_wmask = grant1 ? bus.p1_req_wmask : bus.p0_req_wmask;

    assign cmd_fire  = app_en_q & bus.app_rdy;
    assign data_fire = wren_q & bus.app_wdf_rdy;
    assign cmd_ok    = cmd_done | cmd_fire;
    assign data_ok   = data_done | data_fire;

    assign bus.p0_req_ready = grant0;
    assign bus.p1_req_ready = grant1;
    assign bus.app_en       = app_en_q;
    assign bus.app_cmd      = cmd_q;
    assign bus.app_addr     = addr_q;
    assign bus.app_wdf_wren = wren_q;
    assign bus.app_wdf_end  = wend_q;
    assign bus.app_wdf_data = wdata_q;
    assign bus.app_wdf_mask = wmask_q;
    assign bus.p0_rd_valid  = rd_vld_p1[0];
    assign bus.p1_rd_valid  = rd_vld_p1[1];
    assign bus.p0_rd_data   = rd_data_p1;
    assign bus.p1_rd_data   = rd_data_p1;

    ddr3_arb_tag_fifo #(
        .DEPTH (RD_DEPTH)
    ) u_tag_fifo (
        .clk       (ui_clk),
        .rst_n     (ui_rst_n),
        .push      (tag_push),
        .push_data (cur_port),
        .pop       (tag_pop),
        .pop_data  (tag_pop_data),
        .full      (tag_full),
        .empty     (tag_empty)
    );

    // Grant / issue stage: command and write-data handshakes retire independently.
    always_ff @(posedge ui_clk or negedge ui_rst_n) begin
        if (!ui_rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cur_port   <= 1'b0;
            cmd_done   <= 1'b0;
            data_done  <= 1'b0;
            app_en_q   <= 1'b0;
            wren_q     <= 1'b0;
            wend_q     <= 1'b0;
            cmd_q      <= 3'b000;
            addr_q     <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        state      <= ISSUE;
                        last_grant <= grant1;
                        cur_port   <= grant1;
                        app_en_q   <= 1'b1;
                        cmd_q      <= sel_write ? CMD_WRITE : CMD_READ;
                        addr_q     <= sel_addr;
                        wren_q     <= sel_write;
                        wend_q     <= sel_write;
                        wdata_q    <= sel_wdata;
                        wmask_q    <= sel_wmask;
                        cmd_done   <= 1'b0;
                        data_done  <= ~sel_write;
                    end
                end
                ISSUE: begin
                    if (cmd_fire) begin
                        app_en_q <= 1'b0;
                        cmd_done <= 1'b1;
                    end
                    if (data_fire) begin
                        wren_q    <= 1'b0;
                        wend_q    <= 1'b0;
                        data_done <= 1'b1;
                    end
                    if (cmd_ok && data_ok) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read return stage: one register between controller and requester.
    always_ff @(posedge ui_clk or negedge ui_rst_n) begin
        if (!ui_rst_n) begin
            rd_vld_p1     <= 2'b00;
            rd_data_p1    <= '0;
            rd_orphan_err <= 1'b0;
        end else begin
            rd_vld_p1[0] <= tag_pop & ~tag_pop_data;
            rd_vld_p1[1] <= tag_pop & tag_pop_data;
            if (tag_pop) rd_data_p1 <= bus.app_rd_data;
            if (bus.app_rd_data_valid && tag_empty) rd_orphan_err <= 1'b1;
        end
    end

endmodule
